// File: rtl/csa_result_accumulator_if.sv
// Carry-save product input and accumulated-result output bundle for csa_result_accumulator.
interface csa_result_accumulator_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 16
);
    localparam int unsigned PW = 2 * N;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] z0;
    logic [PW-1:0] z1;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic [7:0]    out_count;
    logic          out_ovf;

    // Producer of beats and consumer of results
    modport master (
        output in_valid, z0, z1, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    // The accumulator itself
    modport slave (
        input  in_valid, z0, z1, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/csa_result_accumulator.sv
// Resolves carry-save product pairs from the Dadda tree, sign-corrects them,
// and accumulates one signed sum per packet delimited by in_last.
// Optional build macro CSA_ACC_SAT_EN: clamp the accumulator on signed
// overflow instead of wrapping; out_ovf behaves the same either way.
module csa_result_accumulator #(
    parameter int unsigned N    = 4,
    parameter int unsigned AW   = 16,
    parameter int unsigned CORR = 1 << (N - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_result_accumulator_if.slave bus
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          in_ready_q;
    logic          out_valid_q;

    logic          s1_valid;
    logic          s1_last;
    logic [PW-1:0] s1_p;

    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          accept_c;
    logic          hs_c;
    logic [AW-1:0] p_ext_c;
    logic [AW-1:0] sum_c;
    logic          ovf_c;
    logic [AW-1:0] acc_nxt_c;

    assign accept_c = bus.in_valid & in_ready_q;
    assign hs_c     = out_valid_q & bus.out_ready;

    // Sign-extend the resolved product and detect signed overflow of the add
    assign p_ext_c = AW'($signed(s1_p));
    assign sum_c   = acc + p_ext_c;
    assign ovf_c   = (acc[AW-1] == p_ext_c[AW-1]) && (sum_c[AW-1] != acc[AW-1]);

`ifdef CSA_ACC_SAT_EN
    localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

    // Clamp toward the sign of the operands when the add overflows
    assign acc_nxt_c = ovf_c ? (acc[AW-1] ? SMIN : SMAX) : sum_c;
`else
    // Plain modulo-2^AW wrap
    assign acc_nxt_c = sum_c;
`endif

    // State register with registered ready/valid decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == S_ACC);
            out_valid_q <= (state_nxt == S_OUT);
        end
    end

    // Next-state logic: accept beats, drain the last product, hold the result
    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC: begin
                if (accept_c && bus.in_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (s1_valid && s1_last) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    // Stage 1: resolve the carry-save pair into a corrected binary product
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_p    <= bus.z0 + bus.z1 + PW'(CORR);
                s1_last <= bus.in_last;
            end
        end
    end

    // Stage 2: accumulate, count beats, track sticky overflow; clear on result handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (hs_c) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (s1_valid) begin
            acc <= acc_nxt_c;
            ovf <= ovf | ovf_c;
            if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_csa_result_accumulator.sv
// Directed self-checking bench for csa_result_accumulator (N=4, AW=16).
module tb_csa_result_accumulator;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    csa_result_accumulator_if #(.N(4), .AW(16)) bus ();

    csa_result_accumulator #(.N(4), .AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        int budget;
        budget = 20;
        bus.z0 = a;
        bus.z1 = b;
        bus.in_last = last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            total++;
            $display("FAIL beat_ready_timeout: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_out();
        int budget;
        budget = 20;
        while (bus.out_valid !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            total++;
            $display("FAIL out_valid_timeout: got out_valid=%b want 1", bus.out_valid);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd0) $display("FAIL reset_out_count: got %0d want 0", bus.out_count); else passed++;
        total++; if (bus.out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", bus.out_ovf); else passed++;
    endtask

    task automatic test_single();
        beat(8'h20, 8'h40, 1'b1);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL single_lat1_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL single_drain_ready: got %b want 0", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL single_lat2_valid: got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 16'd104) $display("FAIL single_data: got %0d want 104", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd1) $display("FAIL single_count: got %0d want 1", bus.out_count); else passed++;
        total++; if (bus.out_ovf !== 1'b0) $display("FAIL single_ovf: got %b want 0", bus.out_ovf); else passed++;
        handshake();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL single_post_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL single_post_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_data !== 16'h0000) $display("FAIL single_post_clear: got %h want 0000", bus.out_data); else passed++;
    endtask

    task automatic test_bubble();
        beat(8'hF0, 8'h00, 1'b0);
        tick();
        total++; if (bus.out_data !== 16'hFFF8) $display("FAIL bubble_running_data: got %h want fff8", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd1) $display("FAIL bubble_running_count: got %0d want 1", bus.out_count); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bubble_running_valid: got %b want 0", bus.out_valid); else passed++;
        beat(8'h00, 8'h00, 1'b0);
        beat(8'h30, 8'h00, 1'b1);
        wait_out();
        total++; if (bus.out_data !== 16'd56) $display("FAIL bubble_data: got %0d want 56", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd3) $display("FAIL bubble_count: got %0d want 3", bus.out_count); else passed++;
        total++; if (bus.out_ovf !== 1'b0) $display("FAIL bubble_ovf: got %b want 0", bus.out_ovf); else passed++;
        handshake();
    endtask

    task automatic test_backpressure();
        beat(8'h20, 8'h40, 1'b1);
        wait_out();
        bus.z0 = 8'h00;
        bus.z1 = 8'h00;
        bus.in_last = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); else passed++;
            total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); else passed++;
            total++; if (bus.out_data !== 16'd104) $display("FAIL bp_out_data[%0d]: got %0d want 104", i, bus.out_data); else passed++;
            tick();
        end
        handshake();
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_resume_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_resume_valid: got %b want 0", bus.out_valid); else passed++;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_next_drain: got %b want 0", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 16'd8) $display("FAIL bp_next_data: got %0d want 8", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd1) $display("FAIL bp_next_count: got %0d want 1", bus.out_count); else passed++;
        handshake();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_data;
`ifdef CSA_ACC_SAT_EN
        exp_data = 16'h7FFF;
`else
        exp_data = 16'h94D4;
`endif
        total++; if (bus.in_ready !== 1'b1) $display("FAIL ovf_start_ready: got %b want 1", bus.in_ready); else passed++;
        for (int i = 0; i < 300; i++) begin
            bus.z0 = 8'h77;
            bus.z1 = 8'h00;
            bus.in_last = (i == 299);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        wait_out();
        total++; if (bus.out_data !== exp_data) $display("FAIL ovf_data: got %h want %h", bus.out_data, exp_data); else passed++;
        total++; if (bus.out_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.out_ovf); else passed++;
        total++; if (bus.out_count !== 8'd255) $display("FAIL ovf_count: got %0d want 255", bus.out_count); else passed++;
        handshake();
        total++; if (bus.out_ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", bus.out_ovf); else passed++;
        total++; if (bus.out_count !== 8'd0) $display("FAIL ovf_count_cleared: got %0d want 0", bus.out_count); else passed++;
    endtask

    task automatic test_reset_mid();
        beat(8'h20, 8'h40, 1'b0);
        beat(8'h20, 8'h40, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.out_data !== 16'h0000) $display("FAIL rstmid_data: got %h want 0000", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd0) $display("FAIL rstmid_count: got %0d want 0", bus.out_count); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_data !== 16'h0000) $display("FAIL rstmid_no_stale: got %h want 0000", bus.out_data); else passed++;
        beat(8'h00, 8'h00, 1'b1);
        wait_out();
        total++; if (bus.out_data !== 16'd8) $display("FAIL rstmid_pkt_data: got %0d want 8", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd1) $display("FAIL rstmid_pkt_count: got %0d want 1", bus.out_count); else passed++;
        handshake();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        beat(8'h77, 8'h00, 1'b0);
        beat(8'h77, 8'h00, 1'b1);
        wait_out();
        total++; if (bus.out_data !== 16'd254) $display("FAIL b2b_a_data: got %0d want 254", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd2) $display("FAIL b2b_a_count: got %0d want 2", bus.out_count); else passed++;
        beat(8'hF0, 8'h00, 1'b0);
        beat(8'hF0, 8'h00, 1'b1);
        wait_out();
        total++; if (bus.out_data !== 16'hFFF0) $display("FAIL b2b_b_data: got %h want fff0", bus.out_data); else passed++;
        total++; if (bus.out_count !== 8'd2) $display("FAIL b2b_b_count: got %0d want 2", bus.out_count); else passed++;
        total++; if (bus.out_ovf !== 1'b0) $display("FAIL b2b_b_ovf: got %b want 0", bus.out_ovf); else passed++;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_done_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 16'h0000) $display("FAIL b2b_done_clear: got %h want 0000", bus.out_data); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.z0 = 8'h00;
        bus.z1 = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_bubble();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/csa_result_accumulator.md
# csa_result_accumulator

Consumes the redundant (carry-save) product pair produced by the signed Dadda multiplier tree and resolves it to a binary two's-complement product. Each resolved product is sign-corrected and then accumulated over a packet of beats delimited by `in_last`. When the packet ends, the block presents one accumulated result on a valid/ready output. It sits directly downstream of `dadda` (`z0`/`z1`) and forms the receiving end of the multiplier's carry-save result interface in the DSP datapath.

## Interface
Parameters:
- `N`, 4: multiplier operand width. Product width is `PW = 2*N`.
- `AW`, 16: accumulator and output width. Must satisfy `AW >= 2*N`.
- `CORR`, `(1 << (N-1))` (8'h08 for N=4): sign-correction constant added to every `z0+z1`.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a carry-save pair is present on `z0`/`z1`.
- `in_ready`  out  1  block accepts the pair this cycle.
- `z0`  in  PW  carry-save vector 0 from the tree.
- `z1`  in  PW  carry-save vector 1 from the tree.
- `in_last`  in  1  the beat is the final beat of its packet.
- `out_valid`  out  1  `out_data` holds a completed packet sum.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  AW  signed accumulated sum.
- `out_count`  out  8  number of beats in the packet; saturates at 255.
- `out_ovf`  out  1  sticky flag: signed overflow occurred in the accumulator during this packet.

## Operation
- Beat accept: a beat is accepted when `in_valid & in_ready`.
- Stage 1 (resolve): `p = (z0 + z1 + CORR) mod 2^PW`, registered along with a last flag and a valid flag.
- Stage 2 (accumulate):
  - `acc <= acc + sext(p, AW)`.
  - Overflow is detected when both operand signs are equal and the sum sign differs; `ovf` is set and stays set for the rest of the packet.
  - `cnt` increments and saturates at 255.
- State machine:
  - ACC: `in_ready = 1`.
  - Accepting a beat with `in_last = 1` moves the block to DRAIN, with `in_ready = 0`.
  - In DRAIN, stage 2 absorbs the last product, then the block moves to OUT with `out_valid = 1`.
  - In OUT, `out_data`, `out_count` and `out_ovf` are frozen.
  - On `out_valid & out_ready`: `acc`, `cnt` and `ovf` clear to 0, and the block returns to ACC.
- Bubbles: `in_valid` low between beats is legal. Stage 2 updates only when the stage-1 valid flag is set.
- `in_last` on the first beat gives a one-beat packet.
- Outputs in ACC and DRAIN: `out_data`, `out_count` and `out_ovf` show the running values, but `out_valid` stays 0.
- Simultaneous events: no input beat is accepted in the cycle that completes an output handshake. ACC resumes the following cycle.
- Reset mid-packet: all partial state is discarded. The next accepted beat starts a new packet.

## Timing
- Reset values:
  - `in_ready = 1` in the first cycle after reset is released.
  - `out_valid = 0`, `out_data = 0`, `out_count = 0`, `out_ovf = 0`.
  - State is ACC; stage-1 valid flag is 0.
- Latency: the last beat is accepted at edge E0, accumulated at edge E0+1, and `out_valid` is high from E0+1 onward.
  - Last-beat accept to `out_valid`: 2 cycles.
- Throughput: 1 beat per cycle within a packet.
- Packet gap: at least 3 cycles between the last beat of one packet and the first beat of the next (DRAIN, OUT, handshake).
- Output handshake:
  - `out_valid` is held until `out_ready`.
  - `out_*` are stable while `out_valid & !out_ready`.
- `in_ready` is a registered state decode and has no combinational path from `out_ready`.

## Configuration
- `CSA_ACC_SAT_EN`:
  - Defined: on overflow the accumulator clamps to `2^(AW-1)-1` for a positive overflow or `-2^(AW-1)` for a negative overflow, and further adds continue from the clamped value.
  - Undefined: the accumulator wraps modulo `2^AW`.
  - `out_ovf` behaves identically in both builds.

## Test plan
- Single-beat packet: `z0 = 8'h20`, `z1 = 8'h40`, `in_last = 1` -> two cycles later `out_valid = 1`, `out_data = 104`, `out_count = 1`, `out_ovf = 0`.
- Three-beat packet with a one-cycle bubble: pairs (8'hF0, 0) giving -8, (0, 0) giving 8, and (8'h30, 0) with last giving 56 -> `out_data = 56`, `out_count = 3`.
- Output backpressure: hold `out_ready = 0` for 5 cycles with `in_valid = 1` -> `in_ready = 0` throughout, `out_data` stable, no beat accepted; the new packet starts 1 cycle after the handshake.
- Overflow: 300 beats of (8'h77, 0), each giving 127; true sum is 38100 ->
  - Without `CSA_ACC_SAT_EN`: `out_data = -27436`.
  - With `CSA_ACC_SAT_EN`: `out_data = 32767`.
  - Both builds: `out_ovf = 1`, `out_count = 255`.
- Reset mid-packet: accept 2 beats of 104, assert `rst` for 1 cycle, then send a 1-beat packet of (8'h00, 8'h00) -> `out_data = 8`, `out_count = 1`.
- Back-to-back packets: assert `out_ready` continuously -> each packet's sum is independent, with no carry-over of `acc`, `cnt` or `ovf`.
